// File: rtl/arbitro_sumador_if.sv
// Bundle between the two adder clients and arbitro_sumador.
// master = client side (drives requests/operands), slave = arbiter side.
interface arbitro_sumador_if #(
  parameter int ANCHO = 4
);
  // Handshake: reqN is a level held with stable aN/bN until ackN; ackN is a
  // one-cycle pulse with suma valid in that cycle; the client must drop reqN
  // in the cycle after ackN or it is taken as a new request.
  logic                 req0;
  logic [ANCHO-1:0]     a0;
  logic [ANCHO-1:0]     b0;
  logic                 req1;
  logic [ANCHO-1:0]     a1;
  logic [ANCHO-1:0]     b1;
  logic                 ack0;
  logic                 ack1;
  logic [2*ANCHO-1:0]   suma;
  logic                 ocupado;
  logic                 turno;

  modport master (
    output req0, a0, b0, req1, a1, b1,
    input  ack0, ack1, suma, ocupado, turno
  );

  modport slave (
    input  req0, a0, b0, req1, a1, b1,
    output ack0, ack1, suma, ocupado, turno
  );
endinterface

// File: rtl/arbitro_sumador.sv
// Two-client arbiter feeding one shared ANCHO-bit adder (IDLE -> CALC -> RESP).
// Define PRIORIDAD_FIJA_EN for fixed priority (client 0 wins ties); default is round-robin.
module arbitro_sumador #(
  parameter int ANCHO = 4
) (
  input  logic                clk,
  input  logic                rst,
  arbitro_sumador_if.slave    bus,
  output logic [1:0]          estado_dbg
);
  localparam int W = 2 * ANCHO;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } estado_t;

  estado_t          state_q, state_d;
  logic [ANCHO-1:0] op_a_q, op_a_d;
  logic [ANCHO-1:0] op_b_q, op_b_d;
  logic             id_q, id_d;
  logic             turno_q, turno_d;
  logic [W-1:0]     suma_q, suma_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             gana;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      id_q    <= 1'b0;
      turno_q <= 1'b1;
      suma_q  <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      id_q    <= id_d;
      turno_q <= turno_d;
      suma_q  <= suma_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    id_d    = id_q;
    turno_d = turno_q;
    suma_d  = suma_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    gana    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          if (bus.req0 && bus.req1) begin
`ifdef PRIORIDAD_FIJA_EN
            gana = 1'b0;
`else
            gana = ~turno_q;
`endif
          end else begin
            gana = bus.req1;
          end
          id_d    = gana;
          turno_d = gana;
          op_a_d  = gana ? bus.a1 : bus.a0;
          op_b_d  = gana ? bus.b1 : bus.b0;
          state_d = CALC;
        end
      end
      CALC: begin
        // Zero-extended add: the carry lands in bit ANCHO, nothing can overflow.
        suma_d  = {{ANCHO{1'b0}}, op_a_q} + {{ANCHO{1'b0}}, op_b_q};
        ack0_d  = ~id_q;
        ack1_d  = id_q;
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.ack0    = ack0_q;
  assign bus.ack1    = ack1_q;
  assign bus.suma    = suma_q;
  assign bus.turno   = turno_q;
  assign bus.ocupado = (state_q != IDLE);
  assign estado_dbg  = state_q;
endmodule

// File: doc/arbitro_sumador.md
# arbitro_sumador

Two-requester arbiter and sequencer for the shared 4-bit adder datapath. Two independent clients present operand pairs with a request line. The block grants one client at a time, latches its operands, and drives them through the single adder instance. It returns the 8-bit registered sum with a one-cycle acknowledge to the granted client. It sits between the hex-decoder front ends and the adder, so one adder serves both display channels.

## Interface
- `ANCHO`, default 4: operand width in bits.
- Result width is 2*`ANCHO` (8 at default), matching the adder's output width.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous reset, active-high.
- `req0`  in  1: request from client 0; level, held until `ack0`.
- `a0`, `b0`  in  ANCHO each: client 0 operands; stable while `req0` is high.
- `req1`  in  1: request from client 1; level, held until `ack1`.
- `a1`, `b1`  in  ANCHO each: client 1 operands; stable while `req1` is high.
- `ack0`  out  1: one-cycle pulse; `suma` holds client 0's result.
- `ack1`  out  1: one-cycle pulse; `suma` holds client 1's result.
- `suma`  out  2*ANCHO: registered result; holds its value until the next result.
- `ocupado`  out  1: high in any state other than IDLE.
- `turno`  out  1: index of the most recently granted client.

## Operation
- FSM states: IDLE, CALC, RESP. Encoding is free.
- IDLE:
  - No request: stay in IDLE.
  - Any request: pick the winner, latch its operands into internal `op_a`/`op_b` and its index into `id`, set `turno <= id`, go to CALC.
- CALC: `suma <= zero-extend(op_a) + zero-extend(op_b)`, go to RESP.
  - Operands are unsigned. The sum is ANCHO+1 bits, zero-extended to 2*ANCHO.
  - There is no overflow. 15+15 = 30 = 8'h1E.
- RESP: drive `ack[id]` high for exactly this cycle, then go to IDLE.
- Arbitration (default is round-robin):
  - Exactly one request: that client wins.
  - Both requesting: the client ≠ `turno` wins.
- Requests are sampled only in IDLE. A request that rises during CALC or RESP waits.
- A client must drop `req` in the cycle after its `ack`. A `req` still high in IDLE after that point is a new request and is served again.
- Operand changes while the client is granted have no effect; the operands were latched in IDLE.
- Reset values: state IDLE; `suma`=0; `ack0`=`ack1`=0; `ocupado`=0; `turno`=1, so client 0 wins the first tie.
- Reset mid-transaction: the transaction is abandoned immediately with no ack. Both clients must re-request.
- `ack0` and `ack1` are never high in the same cycle.

## Timing
- All outputs are registered (`ocupado` may be decoded from the state register).
- Latency:
  - Request sampled at edge E0 (IDLE → CALC).
  - `suma` is valid after edge E1 (CALC → RESP).
  - `ack` is high in the cycle between E1 and E2.
- Throughput: one result per 3 cycles. Under continuous demand from both clients, grants strictly alternate.
- A request can therefore wait for one full transaction (3 cycles) plus its own 3 cycles.
- `suma` is stable from the ack cycle until the next CALC→RESP edge.

## Configuration
- `PRIORIDAD_FIJA_EN` defined: fixed priority. Client 0 always wins when both request, and client 1 can starve. `turno` still reports the last grant.
- `PRIORIDAD_FIJA_EN` undefined (default): round-robin as described above.

## Test plan
- Reset, then idle with no requests for 10 cycles:
  - `ocupado`=0, `ack0`=`ack1`=0, `suma`=0, `turno`=1 throughout.
- Single request, `req0`=1, `a0`=4'h7, `b0`=4'h5:
  - `ack0` pulses exactly 2 cycles after the sampling edge, with `suma`=8'h0C.
  - `ack1` stays 0.
- Worst case, `req1`=1, `a1`=`b1`=4'hF:
  - `suma`=8'h1E at `ack1`; `turno`=1.
- Both requests held continuously, `a0`+`b0`=3+4, `a1`+`b1`=9+9:
  - Round-robin build: acks alternate `ack0` (8'h07), `ack1` (8'h12), `ack0`, … every 3 cycles.
  - With `PRIORIDAD_FIJA_EN`: only `ack0` fires.
- `rst` pulsed asynchronously during CALC of a client 0 transaction:
  - All outputs reset within the same cycle, and no `ack0` follows.
  - After release, the still-asserted `req0` is served with a fresh 2-cycle latency.
- Client 0 changes `a0` from 4'h1 to 4'h9 one cycle after the grant:
  - The result reflects the latched operand (1 + `b0`), not 9.
